// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bus bundle: PC register control, instruction-memory request/response
// channel and the decode-facing output register handshake.
interface if_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] pc_if;
  logic              pc_en;
  logic              redirect;

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_resp_valid;
  logic [31:0]       imem_resp_data;

  logic              id_valid;
  logic              id_ready;
  logic [31:0]       id_instr;
  logic [ADDR_W-1:0] id_pc;

  modport master (
    input  pc_if, redirect, imem_req_ready, imem_resp_valid, imem_resp_data, id_ready,
    output pc_en, imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc
  );

  modport slave (
    output pc_if, redirect, imem_req_ready, imem_resp_valid, imem_resp_data, id_ready,
    input  pc_en, imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch sequencer: one outstanding IMEM read, one-entry output register
// towards decode, PC-register enable and redirect squashing.
//
// state  | meaning
// S_REQ  | may issue a request for pc_if when the output register is free
// S_WAIT | one request outstanding; response is loaded or dropped
module if_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h40000000
) (
  input  logic           CLK,
  input  logic           RST,
  if_fetch_unit_if.master bus
);

  typedef enum logic {S_REQ, S_WAIT} state_t;

  state_t            state;
  logic              drop;
  logic [ADDR_W-1:0] req_pc;
  logic              id_valid_q;
  logic [31:0]       id_instr_q;
  logic [ADDR_W-1:0] id_pc_q;

  logic out_free;
  logic req_valid;
  logic req_fire;
  logic pc_en;
  logic resp_load;

  always_comb begin
    out_free  = !id_valid_q || bus.id_ready;
    req_valid = 1'b0;
    pc_en     = 1'b0;
    if (!RST) begin
      if (state == S_REQ) begin
        req_valid = out_free && !bus.redirect;
        pc_en     = bus.redirect || (req_valid && bus.imem_req_ready);
      end else begin
        pc_en = bus.redirect;
      end
    end
    req_fire  = req_valid && bus.imem_req_ready;
    // A response arriving with a redirect is already on the wrong path.
    resp_load = (state == S_WAIT) && bus.imem_resp_valid && !drop && !bus.redirect;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_REQ;
      drop       <= 1'b0;
      req_pc     <= RESET_PC;
      id_valid_q <= 1'b0;
      id_instr_q <= 32'h0;
      id_pc_q    <= RESET_PC;
    end else begin
      case (state)
        S_REQ: begin
          if (req_fire) begin
            req_pc <= bus.pc_if;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.imem_resp_valid) begin
            drop  <= 1'b0;
            state <= S_REQ;
          end else if (bus.redirect) begin
            drop <= 1'b1;
          end
        end
        default: state <= S_REQ;
      endcase

      // New entry wins over a same-cycle consume; redirect flushes a held entry.
      if (resp_load) begin
        id_valid_q <= 1'b1;
        id_instr_q <= bus.imem_resp_data;
        id_pc_q    <= req_pc;
      end else if (bus.redirect || bus.id_ready) begin
        id_valid_q <= 1'b0;
      end
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = bus.pc_if;
  assign bus.pc_en          = pc_en;
  assign bus.id_valid       = id_valid_q;
  assign bus.id_instr       = id_instr_q;
  assign bus.id_pc          = id_pc_q;

endmodule
